// File: rtl/gdsp_pkg.sv
// Shared DSP definitions: widths, the 33-tap RRC prototype and the
// round-half-up / saturate helper used by the pulse-shaping filters.
package gdsp_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int COEF_WIDTH = 12;
  localparam int NUM_TAPS   = 33;
  localparam int SPS        = 4;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Root-raised-cosine, beta = 0.35, 4 samples/symbol, Q1.11, symmetric
  // about tap 16. Out-of-range indices read as zero so polyphase branches
  // padded past the last tap contribute nothing.
  function automatic logic signed [COEF_WIDTH-1:0] rrc_coeff(input int i);
    int j;
    int v;
    v = 0;
    j = (i > (NUM_TAPS - 1) / 2) ? (NUM_TAPS - 1) - i : i;
    if (i >= 0 && i < NUM_TAPS) begin
      case (j)
        0:  v = 3;
        1:  v = 21;
        2:  v = 15;
        3:  v = -15;
        4:  v = -41;
        5:  v = -24;
        6:  v = 41;
        7:  v = 104;
        8:  v = 91;
        9:  v = -35;
        10: v = -216;
        11: v = -302;
        12: v = -135;
        13: v = 331;
        14: v = 972;
        15: v = 1532;
        16: v = 1753;
        default: v = 0;
      endcase
    end
    return COEF_WIDTH'(v);
  endfunction

  // Drop COEF_WIDTH-1 fraction bits with round-half-up, then clamp to the
  // sample range so overdriven symbols pin instead of wrapping.
  function automatic sample_t round_sat(input logic signed [63:0] acc);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (COEF_WIDTH - 2))) >>> (COEF_WIDTH - 1);
    hi = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (DATA_WIDTH - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rrc_poly_mac.sv
// One channel's polyphase branch: L-term dot product of the symbol delay
// line against the taps of the selected phase, then round and saturate.
module rrc_poly_mac
  import gdsp_pkg::*;
#(
  parameter int DATA_WIDTH = gdsp_pkg::DATA_WIDTH,
  parameter int COEF_WIDTH = gdsp_pkg::COEF_WIDTH,
  parameter int SPS        = gdsp_pkg::SPS,
  parameter int L          = 9,
  parameter int PH_W       = 2
) (
  input  logic [L-1:0][DATA_WIDTH-1:0] d_i,
  input  logic [PH_W-1:0]              phase_i,
  output logic [DATA_WIDTH-1:0]        y_o
);

  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + $clog2(L);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  // Full-precision sum over the branch; phase p uses taps k*SPS+p.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < L; k++) begin
      prod = $signed(d_i[k]) * rrc_coeff(k * SPS + int'(phase_i));
      acc  = acc + ACC_W'(prod);
    end
  end

  assign y_o = round_sat(64'(acc));

endmodule

// File: rtl/rrc_interp_poly.sv
// Multi-channel polyphase RRC interpolator: accepts one symbol per SPS
// output samples, holds the symbol delay lines, phase counter, handshake
// and output register. Arithmetic lives in rrc_poly_mac.
module rrc_interp_poly
  import gdsp_pkg::*;
#(
  parameter int DATA_WIDTH = gdsp_pkg::DATA_WIDTH,
  parameter int COEF_WIDTH = gdsp_pkg::COEF_WIDTH,
  parameter int NUM_TAPS   = gdsp_pkg::NUM_TAPS,
  parameter int SPS        = gdsp_pkg::SPS,
  parameter int NUM_CH     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [$clog2(SPS)-1:0]         m_phase
);

  localparam int L    = (NUM_TAPS + SPS - 1) / SPS;
  localparam int PH_W = $clog2(SPS);

  logic [NUM_CH-1:0][L-1:0][DATA_WIDTH-1:0] line_q, line_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]        y;
  logic [NUM_CH*DATA_WIDTH-1:0]             m_data_q, m_data_d;
  logic [PH_W-1:0]                          ph_q, ph_d, m_phase_q, m_phase_d;
  logic                                     m_valid_q, m_valid_d;
  logic                                     slot_free, accept, emit;

  // Handshake: a new symbol is only taken at phase 0 with room downstream;
  // the other phases drain from the line already held.
  always_comb begin
    slot_free = !m_valid_q || m_ready;
    s_ready   = !rst && (ph_q == '0) && slot_free;
    accept    = s_valid && s_ready;
    emit      = accept || ((ph_q != '0) && slot_free);
  end

  // Next-state: shift in the accepted symbol (d[0] newest) so the phase-0
  // sample sees it in the same cycle; advance phase on every emitted sample.
  always_comb begin
    line_d    = line_q;
    ph_d      = ph_q;
    m_data_d  = m_data_q;
    m_phase_d = m_phase_q;
    m_valid_d = m_ready ? 1'b0 : m_valid_q;
    if (accept) begin
      for (int c = 0; c < NUM_CH; c++)
        line_d[c] = {line_q[c][L-2:0], s_data[c*DATA_WIDTH +: DATA_WIDTH]};
    end
    if (emit) begin
      m_data_d  = y;
      m_phase_d = ph_q;
      m_valid_d = 1'b1;
      ph_d      = (ph_q == PH_W'(SPS - 1)) ? '0 : ph_q + 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rrc_poly_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .SPS        (SPS),
      .L          (L),
      .PH_W       (PH_W)
    ) u_mac (
      .d_i     (line_d[c]),
      .phase_i (ph_q),
      .y_o     (y[c])
    );
  end

  // State register; reset also discards any phases still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q    <= '0;
      ph_q      <= '0;
      m_data_q  <= '0;
      m_phase_q <= '0;
      m_valid_q <= 1'b0;
    end else begin
      line_q    <= line_d;
      ph_q      <= ph_d;
      m_data_q  <= m_data_d;
      m_phase_q <= m_phase_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_phase = m_phase_q;

endmodule

// File: tb/tb_rrc_interp_poly.sv
// Self-checking bench for rrc_interp_poly: every delivered sample is
// compared against a direct zero-insert 33-tap FIR computed over the
// accepted symbol history.
module tb_rrc_interp_poly;

  localparam int DW  = 12;
  localparam int SPS = 4;
  localparam int NT  = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [2*DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [1:0]    m_phase;

  rrc_interp_poly dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_phase (m_phase)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int q0[$];
  int q1[$];
  int kout = 0;
  int sat_pos_idx = -1;
  int sat_neg_idx = -1;
  bit bp_mode = 0;
  bit acc_flag;
  bit held_vld = 0;
  logic [2*DW-1:0] held_data;
  logic [1:0] held_ph;

  int half [0:16] = '{3, 21, 15, -15, -41, -24, 41, 104, 91, -35, -216, -302,
                      -135, 331, 972, 1532, 1753};

  function automatic int tb_coef(input int i);
    return half[(i <= 16) ? i : 32 - i];
  endfunction

  // Direct FIR on the zero-stuffed stream: symbol n sits at index n*SPS.
  function automatic int exp_s(input int ch, input int k);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < NT; i++) begin
      int m;
      m = k - i;
      if (m >= 0 && (m % SPS) == 0)
        acc += longint'(tb_coef(i)) * longint'((ch == 0) ? q0[m / SPS] : q1[m / SPS]);
    end
    r = (acc + 1024) >>> 11;
    if (r > 2047)  r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the falling edge: anything in handshake now fires next edge.
  task automatic score();
    acc_flag = 0;
    if (rst) begin
      held_vld = 0;
      return;
    end
    if (held_vld) begin
      chk("hold_data", m_data, held_data);
      chk("hold_phase", m_phase, held_ph);
      chk("hold_valid", m_valid, 1);
    end
    if (m_valid && m_ready) begin
      chk("phase", m_phase, kout % SPS);
      chk("ch0", $signed(m_data[DW-1:0]), exp_s(0, kout));
      chk("ch1", $signed(m_data[2*DW-1:DW]), exp_s(1, kout));
      if (kout == sat_pos_idx) chk("sat_pos", $signed(m_data[DW-1:0]), 2047);
      if (kout == sat_neg_idx) chk("sat_neg", $signed(m_data[DW-1:0]), -2048);
      kout++;
    end
    held_vld  = m_valid && !m_ready;
    held_data = m_data;
    held_ph   = m_phase;
    if (s_valid && s_ready) begin
      q0.push_back(int'($signed(s_data[DW-1:0])));
      q1.push_back(int'($signed(s_data[2*DW-1:DW])));
      acc_flag = 1;
    end
  endtask

  task automatic tick();
    m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b);
    int n;
    s_valid = 1'b1;
    s_data  = {12'(b), 12'(a)};
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 64);
    if (!acc_flag) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1; s_data = 24'h5A5A5A;

    // Reset state, with a pending handshake that must be ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_mphase", m_phase, 0);
    chk("rst_sready", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_sready", s_ready, 1);
    @(posedge clk); #1;

    // Impulse on ch0, ch1 silent.
    send(12'h400, 0);
    for (int i = 0; i < 8; i++) send(0, 0);
    idle(8);
    chk("impulse_count", kout, 36);

    // Random full-scale stream, free-running output.
    for (int i = 0; i < 48; i++)
      send($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);

    // Same kind of stream under random back-pressure.
    bp_mode = 1;
    for (int i = 0; i < 48; i++)
      send($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
    bp_mode = 0;

    // Underflow: gap right after an accept, line must continue untouched.
    for (int i = 0; i < 10; i++)
      send($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_ready = 1'b1;
      @(negedge clk);
      score();
      if (i >= 5) chk("gap_mvalid", m_valid, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++)
      send($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
    idle(8);

    // Saturation: symbols match phase-0 tap signs (+,-,+,...), then negated.
    base = q0.size();
    sat_pos_idx = (base + 8) * SPS;
    sat_neg_idx = (base + 17) * SPS;
    for (int i = 0; i < 9; i++)
      send((i % 2 == 0) ? 2047 : -2047, (i % 2 == 0) ? 2047 : -2047);
    for (int i = 0; i < 9; i++)
      send((i % 2 == 0) ? -2047 : 2047, (i % 2 == 0) ? -2047 : 2047);
    idle(8);
    chk("sat_count", kout, q0.size() * SPS);

    // Mid-burst reset while ph == 2 (phase 1 is on the output).
    s_valid = 1'b1;
    s_data  = {12'h123, 12'h321};
    n = 0;
    do begin
      m_ready = 1'b1;
      @(negedge clk);
      score();
      n++;
      if (m_valid && m_phase == 2'd1) break;
      @(posedge clk); #1;
    end while (n < 40);
    if (n >= 40) chk("midrst_timeout", 0, 1);
    rst = 1'b1;
    #1;
    chk("midrst_sready_in_rst", s_ready, 0);
    @(posedge clk); #1;
    chk("midrst_mvalid", m_valid, 0);
    chk("midrst_sready", s_ready, 0);
    rst = 1'b0; s_valid = 1'b0;
    q0.delete(); q1.delete();
    kout = 0; held_vld = 0; sat_pos_idx = -1; sat_neg_idx = -1;
    @(negedge clk);
    chk("midrst_release_sready", s_ready, 1);
    chk("midrst_release_mvalid", m_valid, 0);
    @(posedge clk); #1;

    // Clean impulse afterwards, both channels.
    send(12'h400, 2047);
    for (int i = 0; i < 8; i++) send(0, 0);
    idle(8);
    chk("post_rst_count", kout, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/rrc_interp_poly.md
# rrc_interp_poly

Multi-channel polyphase root-raised-cosine interpolator, the successor to `rrc_filter`. It takes one complex symbol per handshake and emits `SPS` pulse-shaped samples per channel, with the zero-insert upsampling done internally. Every output is bit-exact with the direct 33-tap zero-insert FIR. It sits between the QAM16 mapper and the DAC/channel path. It adds ready/valid flow control with back-pressure, run-time stall on symbol underflow, and full generalisation of width, taps, SPS and channel count.

## Interface
- `DATA_WIDTH`, 12: sample width, signed Q1.(DATA_WIDTH-1).
- `COEF_WIDTH`, 12: coefficient width, signed Q1.(COEF_WIDTH-1).
- `NUM_TAPS`, 33: prototype filter length.
- `SPS`, 4: samples per symbol, ≥2.
- `NUM_CH`, 2: independent channels (ch0 = I, ch1 = Q).

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_data`  in  NUM_CH*DATA_WIDTH  symbol; ch k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_valid`  in  1  symbol present.
- `s_ready`  out  1  symbol accepted when `s_valid && s_ready`.
- `m_data`  out  NUM_CH*DATA_WIDTH  shaped sample, same packing.
- `m_valid`  out  1  sample present.
- `m_ready`  in  1  sample consumed when `m_valid && m_ready`.
- `m_phase`  out  clog2(SPS)  polyphase index of the current `m_data`; 0 marks the symbol-centred-start sample.

## Operation
- L = ceil(NUM_TAPS/SPS) taps per phase. Phase p uses coeff[k*SPS+p] for k=0..L-1. Indices ≥ NUM_TAPS read 0.
- Each channel has an L-deep symbol delay line d[0..L-1], where d[0] is the newest symbol.
- Sample for phase p: acc = Σ d[k]·coeff[k*SPS+p]. Accumulator width is DATA_WIDTH+COEF_WIDTH+clog2(L), with no intermediate truncation.
- Output conversion: y = (acc + 2^(COEF_WIDTH-2)) >>> (COEF_WIDTH-1), which is round-half-up. The result then saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Phase counter `ph` runs 0..SPS-1. `slot_free = !m_valid || m_ready`.
- `ph == 0`:
  - `s_ready = slot_free`.
  - On accept: shift the delay line, insert `s_data` at d[0], register the phase-0 sample computed from the updated line, set `m_phase` = 0 and `ph` = 1.
- `ph != 0`:
  - `s_ready` = 0.
  - If `slot_free`: register phase `ph` from the current line, set `m_phase` = ph and `ph` = (ph+1) mod SPS.
- `m_valid` is set when a sample is registered. It is cleared when `m_ready` is high and no new sample is registered that cycle.
- Underflow: at `ph == 0` with `s_valid` low, no sample is produced and `m_valid` falls once the held sample is consumed. When symbols resume, the line continues unchanged, with no zero-stuffing and no discontinuity.
- Back-pressure: while `m_valid && !m_ready`, `m_data`, `m_phase`, `ph` and the delay line are held.
- All channels share `ph` and the handshake; channels are arithmetically independent.

## Timing
- Reset: `m_valid`=0, `m_data`=0, `m_phase`=0, `ph`=0, all delay lines 0, `s_ready`=0 while `rst` is high. The first cycle after release has `s_ready`=1.
- Latency: symbol accepted at edge t → phase-0 sample visible after edge t; phases 1..SPS-1 follow on the next SPS-1 edges if `m_ready` is held high.
- Throughput: one sample per clock with `m_ready` and `s_valid` held high. `s_valid` is accepted exactly every SPS cycles.
- Simultaneous events:
  - At `ph == 0`, output consumption and symbol acceptance in the same cycle is legal and required; there is no bubble.
  - `rst` dominates everything, including an in-flight handshake.
- Reset mid-burst: all pending phases of the current symbol are discarded.
- Equivalence to the causal direct FIR: output stream index n·SPS+p corresponds to direct-FIR output n·SPS+p, one register later. The golden `mode='same'` offset stays (NUM_TAPS-1)/2 + 1 = 17 samples.

## Structure
- `gdsp_pkg` owns: `DATA_WIDTH`, `COEF_WIDTH`, `NUM_TAPS`, `SPS`, `sample_t`, the `rrc_coeff(i)` function, and a shared `round_sat()` function (also used by `rrc_filter`).
- Sub-module `rrc_poly_mac`: one channel's L-term dot product with round/saturate, selected by phase. It is combinational and instantiated NUM_CH times.
- The top level holds the delay lines, the phase counter, the handshake and the output register.

## Test plan
- **Impulse:** ch0 symbol 0x400 then 8 symbols of 0, ch1 = 0, `m_ready`=1 → the first 33 ch0 outputs equal round_sat(coeff[j]·1024 / 2048) for j=0..32, ch1 stays 0, and `m_phase` cycles 0,1,2,3.
- **Golden stream:** 256 symbols from qam16_symbols_I/Q.hex → output matches tx_filtered_I/Q.hex exactly (0 LSB tolerance) at offset 17, with 1024 samples compared per channel.
- **Back-pressure:** same stream with a 50% random `m_ready` → sample sequence identical to the golden stream; `m_data` is stable whenever `m_valid && !m_ready`.
- **Underflow:** `s_valid` dropped for 10 cycles mid-stream → `m_valid` low during the gap; samples resume with the next phase-0 sample; concatenated output equals the golden stream.
- **Saturation:** symbols ±0x7FF matching the sign of each phase-0 tap, then the negated pattern → output clamps to 0x7FF and 0x800 with no wrap.
- **Mid-burst reset:** `rst` high for 1 cycle at `ph`=2 → next cycle `m_valid`=0 and `s_ready`=0; after release `s_ready`=1, and an impulse gives a clean response with no stale history.
